uart_tx_arbiter: RTL

Shares the single UART transmitter (9-bit txd_data, txd_start pulse, busy status) among NUM_REQ requesters.
- Round-robin arbitration between requesters.
- Captures the winner's word and issues the one-cycle txd_start pulse.
- Tracks the transmitter's busy window before granting again.
- Sits between client blocks (status reporters, command responders) and the uart instance.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_DATA_W      = 9;
  localparam int unsigned DEF_WDOG_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // Bits needed to index v items; never returns less than 1.
  function automatic int unsigned arb_clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = arb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               valid_c
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk candidates ptr, ptr+1, ... modulo NUM_REQ and keep the first hit.
  always_comb begin
    gnt_oh_c = '0;
    idx_c    = '0;
    valid_c  = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = (IDX_W+1)'(ptr) + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = IDX_W'(sum);
      if (!valid_c && req[cand]) begin
        valid_c        = 1'b1;
        idx_c          = cand;
        gnt_oh_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Optional busy-rise watchdog: define UART_ARB_WDOG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES,
  localparam int unsigned IDX_W      = arb_clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         uart_txd_data,
  output logic                      uart_txd_start,
  input  logic                      uart_busy,
  output logic [IDX_W-1:0]          gnt_id,
  output logic                      err_timeout
);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    gnt_id_q, gnt_id_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

`ifdef UART_ARB_WDOG_EN
  localparam int unsigned WDOG_W = arb_clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                err_q, err_d;
`else
  // Watchdog depth is irrelevant when the watchdog is not built in.
  if (WDOG_CYCLES == 0) begin : g_wdog_unused
  end
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .ptr      (ptr_q),
    .gnt_oh_c (pick_oh),
    .idx_c    (pick_idx),
    .valid_c  (pick_valid)
  );

  // Next-state and output decode; grants only from IDLE with the transmitter free.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    gnt_id_d = gnt_id_q;
`ifdef UART_ARB_WDOG_EN
    wdog_d   = wdog_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && !uart_busy) begin
          gnt_d    = pick_oh;
          start_d  = 1'b1;
          data_d   = req_data[32'(pick_idx)*DATA_W +: DATA_W];
          gnt_id_d = pick_idx;
          ptr_d    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d  = ST_WAIT_BUSY;
`ifdef UART_ARB_WDOG_EN
          wdog_d   = '0;
`endif
        end
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_ARB_WDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      start_q  <= start_d;
      data_q   <= data_d;
      gnt_id_q <= gnt_id_d;
    end
  end

`ifdef UART_ARB_WDOG_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign gnt            = gnt_q;
  assign uart_txd_start = start_q;
  assign uart_txd_data  = data_q;
  assign gnt_id         = gnt_id_q;

endmodule
